// File: rtl/mem_arb_pkg.sv
// Shared constants and helpers for the memory arbiter and its round-robin pickers.
package mem_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int MAX_PTR_W = $clog2(MAX_REQ);

  // Width of a round-robin pointer for n requesters (at least one bit).
  function automatic int ptr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Next pointer after granting idx: (idx + 1) mod n.
  function automatic int rr_next(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/mem_arbiter_rr_pick.sv
// Round-robin picker: first set request at or above the pointer, wrapping to 0.
module rr_pick
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  localparam int PTR_W = ptr_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  int cand;

  // Walk the requesters starting at the pointer and keep the first one found.
  always_comb begin
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    cand = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = int'(ptr) + k;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      if (!any && req[cand]) begin
        any       = 1'b1;
        gnt[cand] = 1'b1;
        idx       = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one simple dual-port RAM (one write port, one
// registered read port) among NUM_REQ requesters. Writes and reads are
// arbitrated independently; a read hitting the address written in the same
// cycle returns the new write data.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int addr_width = 8,
  parameter int data_width = 8
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_REQ-1:0]               req_valid,
  input  logic [NUM_REQ-1:0]               req_we,
  input  logic [NUM_REQ*addr_width-1:0]    req_addr,
  input  logic [NUM_REQ*data_width-1:0]    req_wdata,
  output logic [NUM_REQ-1:0]               req_gnt,
  output logic [NUM_REQ-1:0]               rsp_valid,
  output logic [data_width-1:0]            rsp_data,
  output logic [data_width-1:0]            ram_din,
  output logic                             ram_write_en,
  output logic [addr_width-1:0]            ram_waddr,
  output logic [addr_width-1:0]            ram_raddr,
  input  logic [data_width-1:0]            ram_dout
);

  localparam int PTR_W = ptr_width(NUM_REQ);

  logic [addr_width-1:0] addr_arr  [NUM_REQ];
  logic [data_width-1:0] wdata_arr [NUM_REQ];

  logic [NUM_REQ-1:0] wr_req, rd_req;
  logic [NUM_REQ-1:0] wr_gnt, rd_gnt;
  logic [PTR_W-1:0]   wr_idx, rd_idx;
  logic               wr_any, rd_any;
  logic               wr_fire, rd_fire;

  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic                  bypass_flag;
  logic [data_width-1:0] bypass_data;

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign addr_arr[g]  = req_addr[g*addr_width +: addr_width];
    assign wdata_arr[g] = req_wdata[g*data_width +: data_width];
  end

  assign wr_req = req_valid & req_we;
  assign rd_req = req_valid & ~req_we;

  rr_pick #(.NUM_REQ(NUM_REQ)) u_wr_pick (
    .req (wr_req),
    .ptr (wr_ptr),
    .gnt (wr_gnt),
    .idx (wr_idx),
    .any (wr_any)
  );

  rr_pick #(.NUM_REQ(NUM_REQ)) u_rd_pick (
    .req (rd_req),
    .ptr (rd_ptr),
    .gnt (rd_gnt),
    .idx (rd_idx),
    .any (rd_any)
  );

  assign wr_fire = wr_any & ~rst;
  assign rd_fire = rd_any & ~rst;

  // Drive grants and RAM pins; idle ports fall back to requester 0's fields.
  always_comb begin
    req_gnt      = rst ? '0 : (wr_gnt | rd_gnt);
    ram_write_en = wr_fire;
    ram_waddr    = wr_fire ? addr_arr[wr_idx]  : addr_arr[0];
    ram_din      = wr_fire ? wdata_arr[wr_idx] : wdata_arr[0];
    ram_raddr    = rd_fire ? addr_arr[rd_idx]  : addr_arr[0];
    rsp_data     = bypass_flag ? bypass_data : ram_dout;
  end

  // Advance pointers past each grant and register the read response and hazard bypass.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      rsp_valid   <= '0;
      bypass_flag <= 1'b0;
      bypass_data <= '0;
    end else begin
      if (wr_fire) wr_ptr <= PTR_W'(rr_next(int'(wr_idx), NUM_REQ));
      if (rd_fire) rd_ptr <= PTR_W'(rr_next(int'(rd_idx), NUM_REQ));
      rsp_valid   <= rd_fire ? rd_gnt : '0;
      bypass_flag <= wr_fire & rd_fire & (ram_waddr == ram_raddr);
      bypass_data <= ram_din;
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed, table-driven bench for mem_arbiter with a behavioural RAM model.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req_valid, req_we;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_gnt, rsp_valid;
  logic [7:0]  rsp_data, ram_din, ram_waddr, ram_raddr, ram_dout;
  logic        ram_write_en;

  logic        pre_we;
  logic [7:0]  pre_addr, pre_data;
  logic [7:0]  mem [256];

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic        rst;
    logic [3:0]  valid, we;
    logic [31:0] addr, wdata;
    logic [3:0]  gnt;
    logic        wen;
    logic [7:0]  waddr, din, raddr;
    logic [3:0]  rsp_v;
    logic        chk_d;
    logic [7:0]  rsp_d;
  } vec_t;

  vec_t tbl[$];

  mem_arbiter #(.NUM_REQ(4), .addr_width(8), .data_width(8)) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_we       (req_we),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .req_gnt      (req_gnt),
    .rsp_valid    (rsp_valid),
    .rsp_data     (rsp_data),
    .ram_din      (ram_din),
    .ram_write_en (ram_write_en),
    .ram_waddr    (ram_waddr),
    .ram_raddr    (ram_raddr),
    .ram_dout     (ram_dout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple dual-port RAM with registered read (old data on same-address write) plus a preload port.
  always @(posedge clk) begin
    if (ram_write_en) mem[ram_waddr] <= ram_din;
    else if (pre_we)  mem[pre_addr]  <= pre_data;
    ram_dout <= mem[ram_raddr];
  end

  function automatic vec_t make_vec(
    input logic r, input logic [3:0] v, input logic [3:0] w,
    input logic [31:0] a, input logic [31:0] d,
    input logic [3:0] g, input logic we_en, input logic [7:0] wa, input logic [7:0] di,
    input logic [7:0] ra, input logic [3:0] rv, input logic cd, input logic [7:0] rd);
    vec_t t;
    t.rst = r; t.valid = v; t.we = w; t.addr = a; t.wdata = d;
    t.gnt = g; t.wen = we_en; t.waddr = wa; t.din = di; t.raddr = ra;
    t.rsp_v = rv; t.chk_d = cd; t.rsp_d = rd;
    return t;
  endfunction

  task automatic check_val(input string tag, input string name,
                           input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s %s: got %0h expected %0h", tag, name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input vec_t v);
    @(posedge clk);
    #1;
    rst       = v.rst;
    req_valid = v.valid;
    req_we    = v.we;
    req_addr  = v.addr;
    req_wdata = v.wdata;
  endtask

  task automatic check_output(input vec_t v, input string tag);
    @(negedge clk);
    check_val(tag, "req_gnt",      32'(req_gnt),      32'(v.gnt));
    check_val(tag, "ram_write_en", 32'(ram_write_en), 32'(v.wen));
    check_val(tag, "ram_waddr",    32'(ram_waddr),    32'(v.waddr));
    check_val(tag, "ram_din",      32'(ram_din),      32'(v.din));
    check_val(tag, "ram_raddr",    32'(ram_raddr),    32'(v.raddr));
    check_val(tag, "rsp_valid",    32'(rsp_valid),    32'(v.rsp_v));
    if (v.chk_d) check_val(tag, "rsp_data", 32'(rsp_data), 32'(v.rsp_d));
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    apply_stimulus(v);
    check_output(v, tag);
  endtask

  initial begin
    int waited;
    logic got;
    logic [7:0] pa [8];
    logic [7:0] pd [8];

    rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wdata = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;

    pa = '{8'h10, 8'h06, 8'h20, 8'h21, 8'h22, 8'h23, 8'h40, 8'h05};
    pd = '{8'hA5, 8'h66, 8'hB0, 8'hB1, 8'hB2, 8'hB3, 8'h77, 8'h00};
    for (int i = 0; i < 8; i++) begin
      @(posedge clk);
      #1;
      pre_we = 1'b1; pre_addr = pa[i]; pre_data = pd[i];
    end
    @(posedge clk);
    #1;
    pre_we = 1'b0;

    //                rst valid we   addr          wdata         gnt  wen waddr  din    raddr  rspv chk rspd
    // reset: requests pending but nothing granted, write from req0 must not land
    tbl.push_back(make_vec(1, 4'hF, 4'h3, 32'h13121110, 32'h0000F1F0, 4'h0, 0, 8'h10, 8'hF0, 8'h10, 4'h0, 0, 8'h00));
    tbl.push_back(make_vec(1, 4'hF, 4'h3, 32'h13121110, 32'h0000F1F0, 4'h0, 0, 8'h10, 8'hF0, 8'h10, 4'h0, 1, 8'hA5));
    // round-robin among four readers
    tbl.push_back(make_vec(0, 4'hF, 4'h0, 32'h23222120, 32'h0,        4'h1, 0, 8'h20, 8'h00, 8'h20, 4'h0, 0, 8'h00));
    tbl.push_back(make_vec(0, 4'hF, 4'h0, 32'h23222120, 32'h0,        4'h2, 0, 8'h20, 8'h00, 8'h21, 4'h1, 1, 8'hB0));
    tbl.push_back(make_vec(0, 4'hF, 4'h0, 32'h23222120, 32'h0,        4'h4, 0, 8'h20, 8'h00, 8'h22, 4'h2, 1, 8'hB1));
    tbl.push_back(make_vec(0, 4'hF, 4'h0, 32'h23222120, 32'h0,        4'h8, 0, 8'h20, 8'h00, 8'h23, 4'h4, 1, 8'hB2));
    tbl.push_back(make_vec(0, 4'hF, 4'h0, 32'h23222120, 32'h0,        4'h1, 0, 8'h20, 8'h00, 8'h20, 4'h8, 1, 8'hB3));
    // single read by req 2 of preloaded 0x10
    tbl.push_back(make_vec(0, 4'h4, 4'h0, 32'h23102120, 32'h0,        4'h4, 0, 8'h20, 8'h00, 8'h10, 4'h1, 1, 8'hB0));
    tbl.push_back(make_vec(0, 4'h0, 4'h0, 32'h23102120, 32'h0,        4'h0, 0, 8'h20, 8'h00, 8'h20, 4'h4, 1, 8'hA5));
    // concurrent write 0x22->0x05 and read 0x06, then read back 0x05
    tbl.push_back(make_vec(0, 4'h3, 4'h1, 32'h00000605, 32'h00000022, 4'h3, 1, 8'h05, 8'h22, 8'h06, 4'h0, 0, 8'h00));
    tbl.push_back(make_vec(0, 4'h8, 4'h0, 32'h05000000, 32'h0,        4'h8, 0, 8'h00, 8'h00, 8'h05, 4'h2, 1, 8'h66));
    // same-address hazard: write 0x3C->0x40 while req 3 reads 0x40
    tbl.push_back(make_vec(0, 4'h9, 4'h1, 32'h40000040, 32'h0000003C, 4'h9, 1, 8'h40, 8'h3C, 8'h40, 4'h8, 1, 8'h22));
    tbl.push_back(make_vec(0, 4'h2, 4'h0, 32'h00004000, 32'h0,        4'h2, 0, 8'h00, 8'h00, 8'h40, 4'h8, 1, 8'h3C));
    tbl.push_back(make_vec(0, 4'h0, 4'h0, 32'h0,        32'h0,        4'h0, 0, 8'h00, 8'h00, 8'h00, 4'h2, 1, 8'h3C));
    // write fairness and pointer wrap 3 -> 0
    tbl.push_back(make_vec(0, 4'h1, 4'h1, 32'h00000050, 32'h00000011, 4'h1, 1, 8'h50, 8'h11, 8'h50, 4'h0, 0, 8'h00));
    tbl.push_back(make_vec(0, 4'h5, 4'h5, 32'h00520050, 32'h00990011, 4'h4, 1, 8'h52, 8'h99, 8'h50, 4'h0, 0, 8'h00));
    tbl.push_back(make_vec(0, 4'h9, 4'h9, 32'h53000050, 32'h33000011, 4'h8, 1, 8'h53, 8'h33, 8'h50, 4'h0, 0, 8'h00));
    tbl.push_back(make_vec(0, 4'h3, 4'h3, 32'h00005150, 32'h00002211, 4'h1, 1, 8'h50, 8'h11, 8'h50, 4'h0, 0, 8'h00));
    tbl.push_back(make_vec(0, 4'h3, 4'h3, 32'h00005150, 32'h00002211, 4'h2, 1, 8'h51, 8'h22, 8'h50, 4'h0, 0, 8'h00));
    // read back the wrapped write
    tbl.push_back(make_vec(0, 4'h1, 4'h0, 32'h00000053, 32'h0,        4'h1, 0, 8'h53, 8'h00, 8'h53, 4'h0, 0, 8'h00));
    tbl.push_back(make_vec(0, 4'h0, 4'h0, 32'h0,        32'h0,        4'h0, 0, 8'h00, 8'h00, 8'h00, 4'h1, 1, 8'h33));

    for (int i = 0; i < tbl.size(); i++) begin
      run_vec(tbl[i], $sformatf("vec%0d", i));
    end

    $display("[TB] reset-mid-read sequence");
    run_vec(make_vec(0, 4'h4, 4'h4, 32'h00600000, 32'h00770000, 4'h4, 1, 8'h60, 8'h77, 8'h00, 4'h0, 0, 8'h00), "rst_w");
    run_vec(make_vec(0, 4'h2, 4'h0, 32'h00006000, 32'h0,        4'h2, 0, 8'h00, 8'h00, 8'h60, 4'h0, 0, 8'h00), "rst_t");
    run_vec(make_vec(1, 4'h1, 4'h1, 32'h00000060, 32'h000000EE, 4'h0, 0, 8'h60, 8'hEE, 8'h60, 4'h0, 0, 8'h00), "rst_a");
    run_vec(make_vec(1, 4'h1, 4'h1, 32'h00000060, 32'h000000EE, 4'h0, 0, 8'h60, 8'hEE, 8'h60, 4'h0, 1, 8'h77), "rst_b");
    run_vec(make_vec(0, 4'hF, 4'hA, 32'h62606160, 32'h00000100, 4'h3, 1, 8'h61, 8'h01, 8'h60, 4'h0, 0, 8'h00), "rel_0");
    run_vec(make_vec(0, 4'h0, 4'h0, 32'h0,        32'h0,        4'h0, 0, 8'h00, 8'h00, 8'h00, 4'h1, 1, 8'h77), "rel_1");

    $display("[TB] bounded fairness wait");
    @(posedge clk);
    #1;
    req_valid = 4'hF; req_we = 4'hF; req_addr = 32'h70707070; req_wdata = 32'h0;
    waited = 0;
    got = 1'b0;
    while (!got && waited < 4) begin
      @(negedge clk);
      if (req_gnt[0]) got = 1'b1;
      waited++;
    end
    check_val("fair", "req0_granted_within_4", 32'(got), 32'd1);
    @(posedge clk);
    #1;
    req_valid = '0; req_we = '0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Round-robin arbiter sharing one simple dual-port `RAM` (one write port, one registered read port) among `NUM_REQ` requesters. Each cycle it grants at most one write and, independently, at most one read. It drives the RAM address, data and enable pins, and returns read data to the granted requester one cycle later. The arbiter and the RAM run on one clock: the RAM's `wclk` and `rclk` are both tied to `clk`.

## Interface
Parameters:
- `NUM_REQ`, 4: number of requesters, 2..8.
- `addr_width`, 8: RAM address width; must match the RAM instance.
- `data_width`, 8: RAM data width; must match the RAM instance.

Ports:
- `clk` in 1: single clock; also drives RAM `wclk` and `rclk`.
- `rst` in 1: asynchronous, active-high reset.
- `req_valid` in NUM_REQ: requester i has an operation pending.
- `req_we` in NUM_REQ: 1 = write, 0 = read, per requester.
- `req_addr` in NUM_REQ*addr_width: flattened; requester i occupies bits [i*addr_width +: addr_width].
- `req_wdata` in NUM_REQ*data_width: flattened write data, same packing.
- `req_gnt` out NUM_REQ: combinational; at most one write grant and one read grant are high per cycle.
- `rsp_valid` out NUM_REQ: registered, one-hot or zero; read data for requester i is valid this cycle.
- `rsp_data` out data_width: read data shared by all requesters; qualified by `rsp_valid`.
- `ram_din` out data_width: to RAM `din`.
- `ram_write_en` out 1: to RAM `write_en`.
- `ram_waddr` out addr_width: to RAM `waddr`.
- `ram_raddr` out addr_width: to RAM `raddr`.
- `ram_dout` in data_width: from RAM `dout`.

## Operation
- An operation transfers in a cycle where `req_valid[i] & req_gnt[i]`. The requester holds valid, we, addr and wdata stable until granted. It may not retract or change the request before the grant.
- Writers are the set `req_valid & req_we`; readers are `req_valid & ~req_we`. Each set has its own round-robin pointer: `wr_ptr` and `rd_ptr`, each $clog2(NUM_REQ) bits.
- Pick rule: the first set bit searching upward from the pointer, wrapping from NUM_REQ-1 to 0.
- After a grant, the pointer becomes (granted index + 1) mod NUM_REQ. The pointer holds when there is no grant.
- Fairness: a continuously pending requester is granted within NUM_REQ cycles.
- Write grant to requester w drives `ram_write_en`=1, `ram_waddr`=addr[w] and `ram_din`=wdata[w]. With no write grant, `ram_write_en`=0, and `ram_waddr`/`ram_din` are don't-care but stable (driven from index 0).
- Read grant to requester r drives `ram_raddr`=addr[r]. With no read grant, `ram_raddr`=addr[0].
- Same-cycle same-address hazard: the RAM returns the old value in that case. The arbiter returns the new write data instead (write-first semantics):
  - It registers a bypass flag and the write data.
  - In the following cycle, `rsp_data` = the bypass data rather than `ram_dout`.
- Responses cannot be backpressured. A requester with a read granted must accept `rsp_valid` the next cycle.
- A requester issues back-to-back reads freely. Responses return in grant order, one per cycle.

## Timing
- Grant is combinational in cycle T from `req_valid`, `req_we` and the pointers. The write commits at the clock edge ending T.
- Read latency is 1: granted at T, the matching `rsp_valid[r]`=1 and `rsp_data` appear in T+1.
- While `rst` is high:
  - `req_gnt`=0, `ram_write_en`=0, `rsp_valid`=0.
  - `wr_ptr`=`rd_ptr`=0.
  - The bypass flag is 0; `rsp_data` follows `ram_dout`.
- Reset asserted mid-operation:
  - A read granted in the cycle before reset produces no `rsp_valid`.
  - No write commits while `rst` is high.
  - RAM contents are not cleared.
- First cycle after reset release: arbitration starts from index 0 for both classes.

## Structure
- A shared package `mem_arb_pkg` holds:
  - the clog2-based pointer-width constant;
  - a `rr_next` function that computes (index + 1) mod NUM_REQ.
- Sub-module `rr_pick`: parameterised by NUM_REQ. It takes a request vector and a pointer, and outputs a one-hot grant plus the binary index. It is instantiated twice, once for writers and once for readers.
- The RAM is instantiated outside `mem_arbiter`. The arbiter only drives its pins.

## Test plan
- Single read: preload addr 0x10=0xA5. Req 2 reads 0x10 → `req_gnt[2]` in T; `rsp_valid`=4'b0100 with `rsp_data`=0xA5 in T+1.
- Round-robin: all 4 requesters hold reads to distinct addresses → grants 0,1,2,3,0 on consecutive cycles; each `rsp_valid` follows its grant by one cycle.
- Concurrent write and read, different addresses: req 0 writes 0x22→0x05 while req 1 reads 0x06 in the same cycle → both granted; `ram_write_en`=1; req 1 receives mem[0x06] in T+1.
- Hazard: req 0 writes 0x3C→0x40 while req 3 reads 0x40 in the same cycle → `rsp_data`=0x3C with `rsp_valid[3]` in T+1; a later read of 0x40 also returns 0x3C.
- Fairness under load: req 0 writes continuously, then req 2 raises a write request → req 2 is granted within 4 cycles; `wr_ptr` advances correctly through the wrap from 3 to 0.
- Reset mid-read: read granted in T, `rst` asserted in T+1 → `rsp_valid` stays 0. After release, the grant goes to requester 0 first, and a write issued before reset remains in the RAM.
